// File: rtl/rx_frame_buffer.sv
// rtl/rx_frame_buffer.sv - store-and-forward RX frame FIFO (optional macro RX_FRAME_TIMEOUT_EN)
module rx_frame_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_LOG2      = 9,
    parameter int MAX_FRAME_WORDS = 256,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  ctrl_rst_cntr,
    output logic [31:0]           stat_frames_passed,
    output logic [31:0]           stat_frames_dropped,
    output logic                  stat_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int FL_W  = $clog2(MAX_FRAME_WORDS + 1);

    typedef enum logic [0:0] {
        WR_ACCEPT = 1'b0,
        WR_DROP   = 1'b1
    } wr_state_t;

    wr_state_t             wr_state;
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         wr_commit;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         fill;
    logic [FL_W-1:0]       frame_len;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  at_max;
    logic                  rd_load;
    logic                  commit_evt;
    logic                  drop_evt;
    logic                  ovf_evt;
    logic                  timeout_hit;

    // Full uses the rd_ptr registered at the start of the cycle, so a read
    // in the same cycle only frees space one cycle later.
    assign fill    = wr_ptr - rd_ptr;
    assign full    = (fill == PW'(DEPTH));
    assign empty   = (rd_ptr == wr_commit);
    assign wr_en   = (wr_state == WR_ACCEPT) && s_axis_tvalid && !full;
    assign at_max  = (frame_len == FL_W'(MAX_FRAME_WORDS - 1));
    assign rd_load = !empty && (!m_axis_tvalid || m_axis_tready);

    assign commit_evt = wr_en && s_axis_tlast;
    assign ovf_evt    = (wr_state == WR_ACCEPT) && s_axis_tvalid && full;
    assign drop_evt   = (ovf_evt && s_axis_tlast)
                      || ((wr_state == WR_DROP) && s_axis_tvalid && s_axis_tlast)
                      || timeout_hit;

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap_cnt;

    assign timeout_hit = (wr_state == WR_ACCEPT) && (frame_len != '0) && !s_axis_tvalid
                       && (gap_cnt == GW'(TIMEOUT_CYCLES - 1));

    // Idle-gap counter inside an open frame; any valid word restarts it.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            gap_cnt <= '0;
        end else if ((wr_state != WR_ACCEPT) || (frame_len == '0) || s_axis_tvalid || timeout_hit) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Buffer storage write port; bit DATA_WIDTH carries tlast.
    always_ff @(posedge m_axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Write FSM: accept words, commit on tlast, rewind to last commit on drop.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            wr_state  <= WR_ACCEPT;
            wr_ptr    <= '0;
            wr_commit <= '0;
            frame_len <= '0;
        end else begin
            case (wr_state)
                WR_ACCEPT: begin
                    if (s_axis_tvalid) begin
                        if (full) begin
                            wr_ptr    <= wr_commit;
                            frame_len <= '0;
                            if (!s_axis_tlast) begin
                                wr_state <= WR_DROP;
                            end
                        end else if (s_axis_tlast) begin
                            wr_ptr    <= wr_ptr + 1'b1;
                            wr_commit <= wr_ptr + 1'b1;
                            frame_len <= '0;
                        end else if (at_max) begin
                            wr_ptr    <= wr_commit;
                            frame_len <= '0;
                            wr_state  <= WR_DROP;
                        end else begin
                            wr_ptr    <= wr_ptr + 1'b1;
                            frame_len <= frame_len + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        wr_ptr    <= wr_commit;
                        frame_len <= '0;
                    end
                end
                WR_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        frame_len <= '0;
                        wr_state  <= WR_ACCEPT;
                    end
                end
                default: begin
                    wr_state <= WR_ACCEPT;
                end
            endcase
        end
    end

    // Read side: the synchronous RAM read lands directly in the output
    // register, reloaded whenever it is empty or being consumed.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (rd_load) begin
            {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            rd_ptr        <= rd_ptr + 1'b1;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Statistics counters, held at zero while ctrl_rst_cntr is high.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn || ctrl_rst_cntr) begin
            stat_frames_passed  <= '0;
            stat_frames_dropped <= '0;
            stat_overflow       <= 1'b0;
        end else begin
            if (commit_evt) begin
                stat_frames_passed <= stat_frames_passed + 1'b1;
            end
            if (drop_evt) begin
                stat_frames_dropped <= stat_frames_dropped + 1'b1;
            end
            if (ovf_evt) begin
                stat_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb/tb_rx_frame_buffer.sv - scoreboard testbench for rx_frame_buffer
module tb_rx_frame_buffer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          ctrl_rst_cntr;
    logic [31:0]   stat_frames_passed;
    logic [31:0]   stat_frames_dropped;
    logic          stat_overflow;

    int checks   = 0;
    int failures = 0;
    bit rand_ready = 1'b0;
    logic [DW:0] exp_q [$];

    always #5 clk = ~clk;

    rx_frame_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH_LOG2(4),
        .MAX_FRAME_WORDS(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .m_axis_aclk(clk),
        .m_axis_aresetn(resetn),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .ctrl_rst_cntr(ctrl_rst_cntr),
        .stat_frames_passed(stat_frames_passed),
        .stat_frames_dropped(stat_frames_dropped),
        .stat_overflow(stat_overflow)
    );

    // Scoreboard: every handshake that the next edge will complete is popped and compared.
    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected got tlast=%0b tdata=%h, required no output", m_axis_tlast, m_axis_tdata);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== e) begin
                    failures++;
                    $display("FAIL out_word got tlast=%0b tdata=%h, required tlast=%0b tdata=%h",
                             m_axis_tlast, m_axis_tdata, e[DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input int n, input logic [DW-1:0] base, input bit keep, input bit with_last);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + DW'(i);
            s_axis_tlast  = with_last && (i == n - 1);
            if (keep) exp_q.push_back({s_axis_tlast, s_axis_tdata});
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_drain got %0d words left, required 0 within 300 cycles", name, exp_q.size());
        end
    endtask

    task automatic check_stats(input string name, input int p, input int d, input bit o);
        checks++;
        if (stat_frames_passed !== 32'(p)) begin
            failures++;
            $display("FAIL %s_passed got %0d required %0d", name, stat_frames_passed, p);
        end
        checks++;
        if (stat_frames_dropped !== 32'(d)) begin
            failures++;
            $display("FAIL %s_dropped got %0d required %0d", name, stat_frames_dropped, d);
        end
        checks++;
        if (stat_overflow !== o) begin
            failures++;
            $display("FAIL %s_overflow got %0b required %0b", name, stat_overflow, o);
        end
    endtask

    task automatic clear_counters();
        ctrl_rst_cntr = 1'b1;
        tick();
        tick();
        ctrl_rst_cntr = 1'b0;
        check_stats("clear", 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got tvalid=%0b tlast=%0b tdata=%h required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        check_stats("reset", 0, 0, 1'b0);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat = 0;
        m_axis_tready = 1'b1;
        send_frame(4, 32'h1, 1'b1, 1'b1);
        while (!m_axis_tvalid && lat < 5) begin
            tick();
            lat++;
        end
        checks++;
        if (lat > 2) begin
            failures++;
            $display("FAIL basic_latency got %0d cycles required <=2", lat);
        end
        wait_drain("basic");
        check_stats("basic", 1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        m_axis_tready = 1'b0;
        send_frame(1, 32'hA5, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === 32'hA5 && m_axis_tlast === 1'b1)) begin
                failures++;
                $display("FAIL hold_cycle%0d got tvalid=%0b tdata=%h tlast=%0b required 1/000000a5/1",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
            end
            tick();
        end
        m_axis_tready = 1'b1;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL hold_release got tvalid=%0b pending=%0d required 0/0", m_axis_tvalid, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        clear_counters();
        m_axis_tready = 1'b0;
        send_frame(6, 32'h100, 1'b1, 1'b1);
        send_frame(6, 32'h200, 1'b1, 1'b1);
        send_frame(6, 32'h300, 1'b0, 1'b1);
        tick();
        check_stats("overflow", 2, 1, 1'b1);
        m_axis_tready = 1'b1;
        wait_drain("overflow");
        send_frame(3, 32'h400, 1'b1, 1'b1);
        wait_drain("overflow_after");
        check_stats("overflow_after", 3, 1, 1'b1);
    endtask

    task automatic test_max_len();
        clear_counters();
        m_axis_tready = 1'b1;
        send_frame(8, 32'h500, 1'b1, 1'b1);
        send_frame(9, 32'h600, 1'b0, 1'b1);
        send_frame(3, 32'h700, 1'b1, 1'b1);
        wait_drain("maxlen");
        check_stats("maxlen", 2, 1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        clear_counters();
        m_axis_tready = 1'b0;
        send_frame(1, 32'h77, 1'b0, 1'b1);
        tick();
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre got tvalid=%0b required 1", m_axis_tvalid);
        end
        send_frame(2, 32'h800, 1'b0, 1'b0);
        resetn = 1'b0;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_tvalid got %0b required 0", m_axis_tvalid);
        end
        resetn = 1'b1;
        send_frame(3, 32'h802, 1'b1, 1'b1);
        tick();
        check_stats("midreset", 1, 0, 1'b0);
        m_axis_tready = 1'b1;
        wait_drain("midreset");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        clear_counters();
        m_axis_tready = 1'b0;
        send_frame(5, 32'h900, 1'b1, 1'b1);
        send_frame(3, 32'hA00, 1'b1, 1'b1);
        send_frame(4, 32'hB00, 1'b1, 1'b1);
        tick();
        m_axis_tready = 1'b1;
        while (m_axis_tvalid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL b2b_throughput got %0d consecutive words required 12", n);
        end
        rand_ready = 1'b1;
        send_frame(4, 32'hC00, 1'b1, 1'b1);
        send_frame(5, 32'hD00, 1'b1, 1'b1);
        send_frame(6, 32'hE00, 1'b1, 1'b1);
        repeat (20) tick();
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        wait_drain("b2b");
        check_stats("b2b", 6, 0, 1'b0);
    endtask

`ifdef RX_FRAME_TIMEOUT_EN
    task automatic test_timeout();
        clear_counters();
        m_axis_tready = 1'b1;
        send_frame(3, 32'hF00, 1'b0, 1'b0);
        repeat (20) tick();
        send_frame(2, 32'hF10, 1'b1, 1'b1);
        wait_drain("timeout");
        check_stats("timeout", 1, 1, 1'b0);
    endtask
`endif

    initial begin
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        ctrl_rst_cntr = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_max_len();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef RX_FRAME_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
